// File: rtl/accum_core_mc.sv
// Multi-cycle accumulator core: fetches {opcode,operand} words over a req/ack port,
// executes against an accumulator and register file, and stops in a sticky HALT state.
module accum_core_mc #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic              retire,
  output logic [CNT_W-1:0]  retired,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] acc_o
);

  localparam int unsigned NREG  = 2**REG_AW;
  localparam int unsigned OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_LDI = 3'd0;
  localparam logic [OPC_W-1:0] OP_LDR = 3'd1;
  localparam logic [OPC_W-1:0] OP_STR = 3'd2;
  localparam logic [OPC_W-1:0] OP_ADD = 3'd3;
  localparam logic [OPC_W-1:0] OP_SUB = 3'd4;
  localparam logic [OPC_W-1:0] OP_LW  = 3'd5;
  localparam logic [OPC_W-1:0] OP_SW  = 3'd6;
  localparam logic [OPC_W-1:0] OP_BNZ = 3'd7;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [DATA_W-1:0] acc_q, acc_d, instr_q, instr_d, wdata_q, wdata_d;
  logic              req_q, req_d, we_q, we_d;
  logic              halted_q, halted_d, retire_q, retire_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [DATA_W-1:0] rf_q [NREG];

  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic              fin;
  logic [OPC_W-1:0]  opc;
  logic [REG_AW-1:0] k;
  logic [DATA_W-1:0] rk, simm;
  logic [ADDR_W-1:0] acc_addr;

  assign opc      = instr_q[DATA_W-1 -: OPC_W];
  assign k        = instr_q[REG_AW-1:0];
  assign rk       = rf_q[k];
  assign simm     = DATA_W'($signed(k));
  assign acc_addr = ADDR_W'(acc_q);

  // Next-state logic; the next fetch request is launched on the edge an instruction completes
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    instr_d   = instr_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    halted_d  = halted_q;
    retire_d  = 1'b0;
    retired_d = retired_q;
    rf_we     = 1'b0;
    rf_wdata  = acc_q;
    fin       = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (!req_q) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = pc_q;
        end else if (mem_ack) begin
          instr_d = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          req_d   = 1'b0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        fin = 1'b1;
        case (opc)
          OP_LDI: acc_d = simm;
          OP_LDR: acc_d = rk;
          OP_STR: rf_we = 1'b1;
          OP_ADD: acc_d = acc_q + rk;
          OP_SUB: acc_d = acc_q - rk;
          OP_LW: begin
            fin     = 1'b0;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = acc_addr;
            state_d = S_MEM;
          end
          OP_SW: begin
            fin     = 1'b0;
            req_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = acc_addr;
            wdata_d = rk;
            state_d = S_MEM;
          end
          OP_BNZ: if (acc_q != '0) pc_d = pc_q + ADDR_W'($signed(rk));
          default: ;
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          fin  = 1'b1;
          we_d = 1'b0;
          if (!we_q) begin
            rf_we    = 1'b1;
            rf_wdata = mem_rdata;
          end
        end
      end
      default: ;
    endcase

    // Retire; a nonzero write into the top register halts instead of fetching
    if (fin) begin
      retire_d = 1'b1;
      if (retired_q != '1) retired_d = retired_q + CNT_W'(1);
      if (rf_we && (k == REG_AW'(NREG - 1)) && (rf_wdata != '0)) begin
        state_d  = S_HALT;
        halted_d = 1'b1;
        req_d    = 1'b0;
        we_d     = 1'b0;
      end else begin
        state_d = S_FETCH;
        req_d   = 1'b1;
        we_d    = 1'b0;
        addr_d  = pc_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      acc_q     <= '0;
      instr_q   <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      halted_q  <= 1'b0;
      retire_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      acc_q     <= acc_d;
      instr_q   <= instr_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      halted_q  <= halted_d;
      retire_q  <= retire_d;
      retired_q <= retired_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[k] <= rf_wdata;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign halted    = halted_q;
  assign retire    = retire_q;
  assign retired   = retired_q;
  assign pc_o      = pc_q;
  assign acc_o     = acc_q;

endmodule

// File: tb/tb_accum_core_mc.sv
// Bench for accum_core_mc: memory responder with programmable waits, an ISA-level
// reference interpreter checked at every retire, directed scenarios and random programs.
module tb_accum_core_mc;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          halted, retire;
  logic [CW-1:0] retired;
  logic [AW-1:0] pc_o;
  logic [DW-1:0] acc_o;

  accum_core_mc #(.REG_AW(5), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .halted(halted), .retire(retire), .retired(retired), .pc_o(pc_o), .acc_o(acc_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory image seen by the DUT and an independent copy owned by the reference model
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  task automatic put(input int a, input logic [DW-1:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) put(i, 8'h00);
  endtask

  // Reference interpreter: one call executes one whole instruction
  logic [7:0] m_acc, m_pc;
  logic [7:0] m_r [32];
  bit         m_halt;
  int         m_ret;

  function automatic void model_reset();
    m_acc = '0;
    m_pc  = '0;
    for (int i = 0; i < 32; i++) m_r[i] = '0;
    m_halt = 1'b0;
    m_ret  = 0;
  endfunction

  function automatic void model_step();
    logic [7:0] ins, v;
    logic [4:0] r;
    ins  = ref_mem[m_pc];
    m_pc = m_pc + 8'd1;
    r    = ins[4:0];
    case (ins[7:5])
      3'd0: m_acc = {{3{r[4]}}, r};
      3'd1: m_acc = m_r[r];
      3'd2: begin m_r[r] = m_acc; if (r == 5'd31 && m_acc != 8'd0) m_halt = 1'b1; end
      3'd3: m_acc = m_acc + m_r[r];
      3'd4: m_acc = m_acc - m_r[r];
      3'd5: begin v = ref_mem[m_acc]; m_r[r] = v; if (r == 5'd31 && v != 8'd0) m_halt = 1'b1; end
      3'd6: ref_mem[m_acc] = m_r[r];
      default: if (m_acc != 8'd0) m_pc = m_pc + m_r[r];
    endcase
    m_ret++;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      model_reset();
    end else begin
      if (retire) begin
        check("retire_after_halt", 32'(m_halt), 0);
        model_step();
        check("acc", 32'(acc_o), 32'(m_acc));
        check("pc", 32'(pc_o), 32'(m_pc));
        check("retired", 32'(retired), (m_ret > 65535) ? 65535 : m_ret);
      end
      check("halted", 32'(halted), 32'(m_halt));
      if (m_halt) check("halt_no_req", 32'(mem_req), 0);
    end
  end

  // Memory responder: fixed_wait >= 0 gives that many wait states, -1 picks 0..max_wait
  int   fixed_wait = 0;
  int   max_wait   = 0;
  bit   force_ack  = 1'b0;
  int   cnt = 0, tgt = 0;
  logic p_req = 1'b0, p_rst = 1'b1;
  logic [16:0] p_bus = '0;
  logic [7:0]  last_wa = '0, last_wd = '0;

  function automatic int pick_wait();
    return (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, max_wait));
  endfunction

  always @(negedge clk) begin
    if (p_req && !mem_ack && !p_rst)
      check("req_stable", 32'({mem_req, mem_we, mem_addr, mem_wdata}), 32'({1'b1, p_bus}));
    if (!mem_req) begin
      mem_ack = 1'b0;
      cnt     = 0;
      tgt     = pick_wait();
    end else begin
      if (mem_ack) begin
        cnt = 0;
        tgt = pick_wait();
      end
      if (cnt >= tgt) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          last_wa = mem_addr;
          last_wd = mem_wdata;
        end
      end else begin
        mem_ack = 1'b0;
        cnt++;
      end
    end
    if (force_ack) mem_ack = 1'b1;
    p_req = mem_req;
    p_rst = reset;
    p_bus = {mem_we, mem_addr, mem_wdata};
  end

  task automatic hold_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic wait_retires(input int n, output int at);
    bit got;
    for (int j = 0; j < n; j++) begin
      got = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (retire) begin got = 1'b1; break; end
      end
      check("retire_timeout", 32'(got), 1);
      if (!got) break;
    end
    at = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, t2, t3, diffs;
    bit seen;

    // T1: reset while a fetch is stalled and mem_ack is high
    fixed_wait = 1;
    hold_reset();
    clear_mem();
    for (int i = 0; i < 16; i++) put(i, 8'h05);
    release_reset();
    wait_retires(3, t0);
    @(posedge clk); #1 reset = 1'b1; force_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t1_req", 32'(mem_req), 0);
    check("t1_pc", 32'(pc_o), 0);
    check("t1_acc", 32'(acc_o), 0);
    check("t1_halted", 32'(halted), 0);
    check("t1_retired", 32'(retired), 0);
    @(posedge clk); #1 force_ack = 1'b0;

    // T2: sign-extended immediates, two-cycle instruction rate
    fixed_wait = 0;
    clear_mem();
    put(0, 8'h1F); put(1, 8'h0F);
    release_reset();
    wait_retires(1, t0);
    check("t2_acc_ff", 32'(acc_o), 32'h0000_00FF);
    wait_retires(1, t1);
    check("t2_acc_0f", 32'(acc_o), 32'h0000_000F);
    check("t2_gap", t1 - t0, 2);

    // T3: add/sub wrap
    hold_reset();
    clear_mem();
    put(0, 8'h01); put(1, 8'h42); put(2, 8'h1F); put(3, 8'h62); put(4, 8'h82);
    release_reset();
    wait_retires(4, t0);
    check("t3_add_wrap", 32'(acc_o), 0);
    wait_retires(1, t0);
    check("t3_sub_wrap", 32'(acc_o), 32'h0000_00FF);

    // T4: three wait states on a fetch
    hold_reset();
    fixed_wait = 3;
    clear_mem();
    put(0, 8'h01);
    release_reset();
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req) begin seen = 1'b1; break; end
    end
    check("t4_req_seen", 32'(seen), 1);
    for (int i = 0; i < 4; i++) begin
      check("t4_req_held", 32'(mem_req), 1);
      check("t4_addr_held", 32'(mem_addr), 0);
      check("t4_pc_before_ack", 32'(pc_o), 0);
      @(negedge clk);
    end
    check("t4_pc_after_ack", 32'(pc_o), 1);
    check("t4_req_exec", 32'(mem_req), 0);

    // T5: SW/LW through an accumulator address
    hold_reset();
    fixed_wait = 0;
    clear_mem();
    put(0, 8'h08); put(1, 8'h41); put(2, 8'h61); put(3, 8'h41); put(4, 8'h61);
    put(5, 8'hA3); put(6, 8'h41); put(7, 8'h61); put(8, 8'hC3); put(9, 8'hA4);
    put(10, 8'h24); put(8'h20, 8'hA5);
    release_reset();
    wait_retires(8, t0);
    check("t5_acc_40", 32'(acc_o), 32'h0000_0040);
    wait_retires(1, t1);
    check("t5_sw_cycles", t1 - t0, 3);
    check("t5_sw_addr", 32'(last_wa), 32'h0000_0040);
    check("t5_sw_data", 32'(last_wd), 32'h0000_00A5);
    wait_retires(1, t2);
    check("t5_lw_cycles", t2 - t1, 3);
    wait_retires(1, t3);
    check("t5_lw_result", 32'(acc_o), 32'h0000_00A5);
    check("t5_ldr_cycles", t3 - t2, 2);
    check("t5_mem_40", 32'(mem[8'h40]), 32'h0000_00A5);

    // T6: backward branch, not-taken branch, zero and nonzero writes to R31
    hold_reset();
    clear_mem();
    put(0, 8'h1E); put(1, 8'h45); put(2, 8'h01); put(3, 8'h46);
    for (int i = 4; i < 9; i++) put(i, 8'h25);
    put(9, 8'h66); put(10, 8'hE5); put(11, 8'h5F); put(12, 8'h03); put(13, 8'h5F);
    release_reset();
    wait_retires(10, t0);
    check("t6_acc_ff", 32'(acc_o), 32'h0000_00FF);
    wait_retires(1, t0);
    check("t6_bnz_taken", 32'(pc_o), 9);
    wait_retires(1, t0);
    check("t6_acc_zero", 32'(acc_o), 0);
    wait_retires(1, t0);
    check("t6_bnz_not_taken", 32'(pc_o), 11);
    wait_retires(1, t0);
    check("t6_zero_no_halt", 32'(halted), 0);
    check("t6_pc_12", 32'(pc_o), 12);
    wait_retires(2, t0);
    check("t6_halted", 32'(halted), 1);
    check("t6_retired", 32'(retired), 16);
    repeat (5) begin
      @(negedge clk);
      check("t6_halt_req", 32'(mem_req), 0);
      check("t6_halt_pc", 32'(pc_o), 14);
    end

    // Random programs with random wait states
    for (int s = 0; s < 4; s++) begin
      hold_reset();
      fixed_wait = -1;
      max_wait   = 2;
      for (int i = 0; i < 256; i++) put(i, 8'($urandom));
      release_reset();
      for (int n = 0; n < 200; n++) begin
        if (halted) break;
        wait_retires(1, t0);
      end
      repeat (4) @(negedge clk);
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
      check("rand_mem_image", diffs, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
